shared_mem_responder: RTL



---
 rtl/shared_mem_responder_pkg.sv | 20 ++
 rtl/shared_mem_responder_if.sv | 32 +++
 rtl/shared_mem_responder_rr_arbiter.sv | 37 +++
 rtl/shared_mem_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/shared_mem_responder_pkg.sv
// Shared types and defaults for the shared-memory responder.
package shared_mem_responder_pkg;

  localparam int DEF_MEM_WIDTH = 32;
  localparam int DEF_MEM_SIZE  = 256;
  localparam int DEF_NUM_PORTS = 2;
  localparam int BYTE_ADDR_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Width of a port index; a single-port system still gets one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Request/response bundle between the Core ports and the memory responder.
interface shared_mem_responder_if
  import shared_mem_responder_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH
);
  localparam int ID_W = id_width(NUM_PORTS);

  logic [NUM_PORTS-1:0]             req;
  logic [NUM_PORTS-1:0]             we;
  logic [NUM_PORTS*BYTE_ADDR_W-1:0] addr;
  logic [NUM_PORTS*MEM_WIDTH-1:0]   wdata;
  logic [NUM_PORTS-1:0]             ack;
  logic [MEM_WIDTH-1:0]             rdata;
  logic                             err;
  logic                             busy;
  logic [ID_W-1:0]                  grant_id;

  // Requesters (Cores) drive the request side.
  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err, busy, grant_id
  );

  // The responder serves the requests.
  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err, busy, grant_id
  );

endinterface

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module rr_arbiter
  import shared_mem_responder_pkg::*;
#(
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int ID_W      = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [ID_W-1:0]      ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [ID_W-1:0]      grant_idx_o,
  output logic                 valid_o
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Scan ports starting at the pointer; the first requester found wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand     = (int'(ptr_i) + i) % NUM_PORTS;
      cand_idx = ID_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        grant_idx_o       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Shared word-addressed memory serving NUM_PORTS requesters, one access at a time.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter  int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter  int MEM_SIZE  = DEF_MEM_SIZE,
  parameter  int NUM_PORTS = DEF_NUM_PORTS,
  localparam int ADDR_BITS = $clog2(MEM_SIZE),
  localparam int ID_W      = id_width(NUM_PORTS)
) (
  input logic                   clk,
  input logic                   reset,
  shared_mem_responder_if.slave bus
);

  localparam int                   WADDR_W    = BYTE_ADDR_W - 2;
  localparam logic [WADDR_W-1:0]   WORD_LIMIT = WADDR_W'(MEM_SIZE);

  // Request as latched at grant; the byte offset is dropped at capture.
  typedef struct packed {
    logic                 we;
    logic [WADDR_W-1:0]   waddr;
    logic [MEM_WIDTH-1:0] wdata;
  } txn_t;

  state_e               state_q, state_d;
  txn_t                 txn_q, txn_d, sel_txn;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [MEM_WIDTH-1:0] mem_q [MEM_SIZE];

  logic [NUM_PORTS-1:0] arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;
  logic                 in_range;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 mem_we;
  logic                 unused_byte_off;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req_i       (bus.req),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  // AND-OR select of the winning port's request fields.
  always_comb begin
    sel_txn         = '0;
    unused_byte_off = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      unused_byte_off = unused_byte_off ^ (^bus.addr[p*BYTE_ADDR_W +: 2]);
      if (arb_grant[p]) begin
        sel_txn.we    = bus.we[p];
        sel_txn.waddr = bus.addr[p*BYTE_ADDR_W+2 +: WADDR_W];
        sel_txn.wdata = bus.wdata[p*MEM_WIDTH +: MEM_WIDTH];
      end
    end
  end

  assign in_range = (txn_q.waddr < WORD_LIMIT);
  assign word_idx = txn_q.waddr[ADDR_BITS-1:0];
  // Reset in ACCESS wins over the store, so a half-finished write never lands.
  assign mem_we   = (state_q == ST_ACCESS) && !reset && txn_q.we && in_range;

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: IDLE -> ACCESS on any request, then RESP, then back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (arb_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: capture at grant, perform the read/range check in ACCESS.
  always_comb begin
    txn_d      = txn_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (state_q == ST_IDLE && arb_valid) begin
      txn_d      = sel_txn;
      grant_id_d = arb_idx;
      ptr_d      = (arb_idx == ID_W'(NUM_PORTS - 1)) ? '0 : arb_idx + ID_W'(1);
    end
    if (state_q == ST_ACCESS) begin
      rdata_d = (in_range && !txn_q.we) ? mem_q[word_idx] : '0;
      err_d   = !in_range;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      txn_q      <= '0;
      ptr_q      <= '0;
      grant_id_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      txn_q      <= txn_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive reset and map onto plain RAM.
    if (mem_we) mem_q[word_idx] <= txn_q.wdata;
  end

  // FSM outputs: response fields exist only in RESP and vanish under reset.
  always_comb begin
    bus.ack   = '0;
    bus.rdata = '0;
    bus.err   = 1'b0;
    if (state_q == ST_RESP && !reset) begin
      bus.ack[grant_id_q] = 1'b1;
      bus.rdata           = rdata_q;
      bus.err             = err_q;
    end
    bus.busy     = (state_q != ST_IDLE);
    bus.grant_id = grant_id_q;
  end

endmodule
